// File: rtl/freq_m_multi.sv
// freq_m_multi: multi-channel frequency meter with a shared contiguous gate window and valid/ack results
module freq_m_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int DEL_W       = 3,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [DEL_W-1:0]  time_del,
  input  logic [N_CH-1:0]   sig_in,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [N_CH-1:0]   res_ovf,
  output logic              res_valid,
  input  logic              res_ack,
  output logic              res_overrun,
  output logic              gate_tick,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;
  localparam int MAXSH = (1 << DEL_W) - 1;
  localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync [N_CH];
  logic [N_CH-1:0] prev, edg, sat, full, tot_sat, snap_ovf;
  logic [CNT_W-1:0] cnt [N_CH], res [N_CH], tot [N_CH], snap [N_CH];
  logic [CNT_W+MAXSH-1:0] wide [N_CH];
  logic [GATE_W-1:0] gcnt, gate_len, len_raw, len_nx;
  logic [DEL_W-1:0] del;
  logic [ARM_W-1:0] arm_cnt;
  logic arm_done, win_end, load;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) sync[i] <= '0;
      prev <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], sig_in[i]};
        prev[i] <= sync[i][SYNC_STAGES-1];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb state_nx = !enable ? IDLE : state == IDLE ? ARM : (state == ARM && !arm_done) ? ARM : GATE;
  always_comb begin
    busy     = state != IDLE;
    arm_done = state == ARM && arm_cnt == ARM_W'(SYNC_STAGES);
    win_end  = state == GATE && enable && gcnt == gate_len - 1'b1;
    gate_tick = win_end;
    load     = (arm_done && enable) || win_end;
    len_raw  = gate_cycles >> time_del;
    len_nx   = len_raw == '0 ? GATE_W'(1) : len_raw;
  end
  // Snapshot includes an edge landing on the window's last cycle, then scales with saturation
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      edg[i]      = sync[i][SYNC_STAGES-1] & ~prev[i];
      full[i]     = &cnt[i];
      tot[i]      = cnt[i] + CNT_W'(edg[i] & ~full[i]);
      tot_sat[i]  = sat[i] | (edg[i] & full[i]);
      wide[i]     = {{MAXSH{1'b0}}, tot[i]} << del;
      snap[i]     = |wide[i][CNT_W+MAXSH-1:CNT_W] ? '1 : wide[i][CNT_W-1:0];
      snap_ovf[i] = tot_sat[i] | (|wide[i][CNT_W+MAXSH-1:CNT_W]);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_cnt  <= '0;
      gcnt     <= '0;
      gate_len <= '0;
      del      <= '0;
      sat      <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      arm_cnt <= state == ARM ? arm_cnt + 1'b1 : '0;
      gcnt    <= load ? '0 : state == GATE ? gcnt + 1'b1 : gcnt;
      if (load) begin
        gate_len <= len_nx;
        del      <= time_del;
      end
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= load ? '0 : state == GATE ? tot[i] : cnt[i];
        sat[i] <= load ? 1'b0 : state == GATE ? tot_sat[i] : sat[i];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_ovf     <= '0;
      res_valid   <= 1'b0;
      res_overrun <= 1'b0;
      for (int i = 0; i < N_CH; i++) res[i] <= '0;
    end else begin
      if (win_end) begin
        res_ovf <= snap_ovf;
        for (int i = 0; i < N_CH; i++) res[i] <= snap[i];
      end
      res_valid   <= win_end | (res_valid & ~res_ack);
      res_overrun <= (win_end & res_valid & ~res_ack) | (res_overrun & ~(res_ack & res_valid));
    end
  end
  assign rd_data = ({1'b0, rd_sel} < (SEL_W+1)'(N_CH)) ? res[rd_sel] : '0;
endmodule

// File: tb/tb_freq_m_multi.sv
// tb_freq_m_multi: table vectors, corner sequences and randomized windows against an edges-per-window model
module tb_freq_m_multi;
  localparam int N = 3, SS = 2;
  logic clk = 0, reset = 0, enable = 0, res_ack = 0;
  logic [31:0] gate_cycles = 0;
  logic [2:0] time_del = 0;
  logic [N-1:0] sig_in = '0;
  logic [1:0] rd_sel = 0;
  logic [7:0] rd_data;
  logic [N-1:0] res_ovf;
  logic res_valid, res_overrun, gate_tick, busy;
  int checks = 0, errors = 0;
  int per [N] = '{0, 0, 0};
  int ph [N] = '{0, 0, 0};
  logic tk;

  freq_m_multi #(.N_CH(N), .CNT_W(8), .GATE_W(32), .DEL_W(3), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .gate_cycles(gate_cycles), .time_del(time_del),
    .sig_in(sig_in), .rd_sel(rd_sel), .rd_data(rd_data), .res_ovf(res_ovf), .res_valid(res_valid),
    .res_ack(res_ack), .res_overrun(res_overrun), .gate_tick(gate_tick), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {int gc; int td; int ch; int p; int exp_d; int exp_o;} vec_t;
  vec_t tv [9];
  int plist [12] = '{0, 2, 3, 4, 5, 6, 10, 12, 15, 20, 30, 60};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: sample gate_tick at the falling edge, then advance each periodic source
  task automatic step();
    @(negedge clk);
    tk = gate_tick;
    for (int c = 0; c < N; c++) begin
      if (per[c] == 0) begin
        ph[c] = 0;
        sig_in[c] = 1'b0;
      end else begin
        ph[c] = (ph[c] + 1) % per[c];
        sig_in[c] = ph[c] < per[c] / 2;
      end
    end
  endtask

  task automatic wait_tick(int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tk && n < budget);
    chk("tick_seen", 32'(tk), 1);
  endtask

  task automatic rd(int c, output logic [7:0] d);
    rd_sel = 2'(c);
    #1;
    d = rd_data;
  endtask

  task automatic ack();
    res_ack = 1;
    step();
    res_ack = 0;
  endtask

  task automatic setup(int gc, int td, int p0, int p1, int p2);
    enable = 0;
    repeat (3) step();
    gate_cycles = 32'(gc);
    time_del = 3'(td);
    per[0] = p0; per[1] = p1; per[2] = p2;
    repeat (5) step();
  endtask

  // Edges in a window of gl cycles from a period-p source, 8-bit saturating count, saturating scale
  function automatic logic [8:0] model(int gl, int td, int p);
    longint v = p != 0 ? gl / p : 0;
    logic o = 0;
    if (v > 255) begin v = 255; o = 1; end
    v = v << td;
    if (v > 255) begin v = 255; o = 1; end
    return {o, 8'(v)};
  endfunction

  initial begin
    int n, gl, td, gc, ackf, pv;
    logic [7:0] d;
    logic [8:0] m;
    logic [N-1:0] eo;
    tv[0] = '{100, 0, 0, 10, 10, 0};
    tv[1] = '{100, 2, 1, 5, 20, 0};
    tv[2] = '{1000, 0, 2, 2, 255, 1};
    tv[3] = '{120, 1, 0, 3, 40, 0};
    tv[4] = '{510, 0, 1, 2, 255, 0};
    tv[5] = '{512, 0, 2, 2, 255, 1};
    tv[6] = '{256, 1, 0, 2, 128, 0};
    tv[7] = '{1024, 2, 1, 2, 255, 1};
    tv[8] = '{103, 3, 2, 4, 24, 0};
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_overrun", 32'(res_overrun), 0);
    chk("rst_tick", 32'(gate_tick), 0);
    chk("rst_ovf", 32'(res_ovf), 0);
    for (int c = 0; c < N; c++) begin
      rd(c, d);
      chk("rst_data", 32'(d), 0);
    end
    reset = 1;
    step();
    for (int i = 0; i < 9; i++) begin
      setup(tv[i].gc, tv[i].td, tv[i].ch == 0 ? tv[i].p : 0, tv[i].ch == 1 ? tv[i].p : 0, tv[i].ch == 2 ? tv[i].p : 0);
      gl = tv[i].gc >> tv[i].td;
      enable = 1;
      wait_tick(gl + SS + 10, n);
      wait_tick(gl + 5, n);
      chk("window_len", 32'(n), 32'(gl));
      step();
      rd(tv[i].ch, d);
      chk("vec_data", 32'(d), 32'(tv[i].exp_d));
      chk("vec_ovf", 32'(res_ovf), 32'(tv[i].exp_o << tv[i].ch));
      rd((tv[i].ch + 1) % N, d);
      chk("vec_idle_ch", 32'(d), 0);
      rd(3, d);
      chk("vec_sel_oob", 32'(d), 0);
      chk("vec_valid", 32'(res_valid), 1);
      chk("vec_overrun", 32'(res_overrun), 1);
      ack();
      chk("ack_valid", 32'(res_valid), 0);
      chk("ack_overrun", 32'(res_overrun), 0);
    end
    setup(100, 0, 10, 0, 0);
    enable = 1;
    wait_tick(120, n);
    step();
    ack();
    repeat (38) step();
    enable = 0;
    step();
    chk("abort_busy", 32'(busy), 0);
    n = 0;
    repeat (150) begin
      step();
      n += int'(tk) + int'(res_valid);
    end
    chk("abort_quiet", 32'(n), 0);
    enable = 1;
    wait_tick(200, n);
    chk("rearm_latency", 32'(n), 32'(SS + 1 + 100));
    step();
    rd(0, d);
    chk("rearm_data", 32'(d), 10);
    chk("rearm_valid", 32'(res_valid), 1);
    chk("rearm_overrun", 32'(res_overrun), 0);
    ack();
    for (int it = 0; it < 15; it++) begin
      gl = $urandom_range(0, 1) != 0 ? 60 : 120;
      td = int'($urandom_range(0, 4));
      gc = (gl << td) | int'($urandom_range(0, (1 << td) - 1));
      ackf = int'($urandom_range(0, 1));
      setup(gc, td, plist[$urandom_range(0, 11)], plist[$urandom_range(0, 11)], plist[$urandom_range(0, 11)]);
      enable = 1;
      wait_tick(gl + SS + 10, n);
      step();
      if (ackf != 0) ack();
      wait_tick(gl + 5, n);
      step();
      eo = '0;
      for (int c = 0; c < N; c++) begin
        pv = per[c];
        m = model(gl, td, pv);
        eo[c] = m[8];
        rd(c, d);
        chk("rnd_data", 32'(d), 32'(m[7:0]));
      end
      chk("rnd_ovf", 32'(res_ovf), 32'(eo));
      chk("rnd_valid", 32'(res_valid), 1);
      chk("rnd_overrun", 32'(res_overrun), 32'(ackf == 0));
      ack();
    end
    setup(3, 3, 2, 0, 0);
    enable = 1;
    wait_tick(20, n);
    repeat (5) begin
      step();
      chk("clamp_tick", 32'(tk), 1);
    end
    #2 reset = 0;
    #1;
    chk("areset_busy", 32'(busy), 0);
    chk("areset_valid", 32'(res_valid), 0);
    chk("areset_overrun", 32'(res_overrun), 0);
    chk("areset_tick", 32'(gate_tick), 0);
    chk("areset_ovf", 32'(res_ovf), 0);
    rd(0, d);
    chk("areset_data", 32'(d), 0);
    enable = 0;
    step();
    reset = 1;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
